// File: rtl/fb_page_ctrl.sv
// Double-buffered Game Boy framebuffer page controller: fills the back page from
// decoded GB pixels, swaps pages only at VGA frame boundaries, and requests blanking when GB video stops.
module fb_page_ctrl #(
  parameter int PIXELS       = 23040,
  parameter int BLANK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_frame_start,
  input  logic        in_wr,
  input  logic [14:0] in_addr,
  input  logic [1:0]  in_data,
  input  logic        vga_frame_end,
  input  logic [14:0] vga_rdaddr,
  output logic        fb_wren,
  output logic [15:0] fb_wraddr,
  output logic [1:0]  fb_data,
  output logic [15:0] fb_rdaddr,
  output logic        blank,
  output logic [7:0]  drop_count
);
  localparam logic [15:0] PIX16   = 16'(PIXELS);
  localparam logic [7:0]  BLANK8  = 8'(BLANK_FRAMES);

  typedef enum logic [1:0] {IDLE, FILL, READY, SKIP} state_t;

  state_t      state;
  logic        front_page;
  logic [15:0] count;
  logic [7:0]  miss;
  logic        addr_ok, wr_ok;
  logic [7:0]  drop_inc, miss_inc;

  assign addr_ok   = {1'b0, in_addr} < PIX16;
  // A frame start in the same cycle as a pixel always wins over the pixel.
  assign wr_ok     = (state == FILL) && in_wr && !in_frame_start && addr_ok;
  assign drop_inc  = (drop_count == 8'hFF) ? drop_count : drop_count + 8'd1;
  assign miss_inc  = (miss == 8'hFF) ? miss : miss + 8'd1;
  assign fb_rdaddr = {front_page, vga_rdaddr};

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      front_page <= 1'b0;
      count      <= '0;
      fb_wren    <= 1'b0;
      fb_wraddr  <= '0;
      fb_data    <= '0;
      drop_count <= '0;
      miss       <= '0;
      blank      <= 1'b1;
    end else begin
      fb_wren <= wr_ok;
      if (wr_ok) begin
        fb_wraddr <= {~front_page, in_addr};
        fb_data   <= in_data;
      end

      case (state)
        IDLE: if (in_frame_start) begin
          state <= FILL;
          count <= '0;
        end
        FILL: if (in_frame_start) begin
          drop_count <= drop_inc;
          count      <= '0;
        end else if (wr_ok) begin
          count <= count + 16'd1;
          if (count + 16'd1 == PIX16) state <= READY;
        end
        // A full frame is waiting; the swap happens before any same-cycle start.
        READY, SKIP: if (vga_frame_end) begin
          front_page <= ~front_page;
          if (in_frame_start) begin
            state <= FILL;
            count <= '0;
          end else begin
            state <= IDLE;
          end
        end else if (in_frame_start) begin
          drop_count <= drop_inc;
          state      <= SKIP;
        end
        default: state <= IDLE;
      endcase

      if (in_frame_start) begin
        miss  <= '0;
        blank <= 1'b0;
      end else if (vga_frame_end) begin
        miss <= miss_inc;
        if (miss_inc >= BLANK8) blank <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_fb_page_ctrl.sv
// Bench for fb_page_ctrl: directed frame scenarios plus random traffic, checked each cycle
// against a frame-level model (filling / full-frame-waiting flags, plain counters).
module tb_fb_page_ctrl;
  localparam int PIXELS       = 23040;
  localparam int BLANK_FRAMES = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_frame_start = 1'b0, in_wr = 1'b0, vga_frame_end = 1'b0;
  logic [14:0] in_addr = '0, vga_rdaddr = '0;
  logic [1:0]  in_data = '0;
  logic        fb_wren, blank;
  logic [15:0] fb_wraddr, fb_rdaddr;
  logic [1:0]  fb_data;
  logic [7:0]  drop_count;

  always #5 clk = ~clk;

  fb_page_ctrl #(.PIXELS(PIXELS), .BLANK_FRAMES(BLANK_FRAMES)) dut (
    .clk(clk), .rst(rst), .in_frame_start(in_frame_start), .in_wr(in_wr),
    .in_addr(in_addr), .in_data(in_data), .vga_frame_end(vga_frame_end),
    .vga_rdaddr(vga_rdaddr), .fb_wren(fb_wren), .fb_wraddr(fb_wraddr),
    .fb_data(fb_data), .fb_rdaddr(fb_rdaddr), .blank(blank), .drop_count(drop_count)
  );

  int total = 0, bad = 0, nwr = 0;

  // Model: is a frame being collected, is a complete frame waiting for a swap.
  bit          m_front = 0, m_filling = 0, m_full = 0, m_blank = 1;
  int          m_count = 0, m_drops = 0, m_miss = 0;
  bit          e_wren = 0;
  logic [15:0] e_wraddr = '0;
  logic [1:0]  e_data = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model(input bit r, fs, wr, input logic [14:0] a, input logic [1:0] d, input bit vfe);
    if (r) begin
      m_front = 0; m_filling = 0; m_full = 0; m_count = 0; m_drops = 0;
      m_miss = 0; m_blank = 1; e_wren = 0; e_wraddr = '0; e_data = '0;
      return;
    end
    e_wren = 0;
    if (m_full) begin
      if (vfe) begin
        m_front = !m_front; m_full = 0;
        if (fs) begin m_filling = 1; m_count = 0; end
      end else if (fs) begin
        m_drops = (m_drops < 255) ? m_drops + 1 : 255;
      end
    end else if (m_filling) begin
      if (fs) begin
        m_drops = (m_drops < 255) ? m_drops + 1 : 255;
        m_count = 0;
      end else if (wr && int'(a) < PIXELS) begin
        e_wren = 1; e_wraddr = {!m_front, a}; e_data = d;
        m_count++;
        if (m_count == PIXELS) begin m_filling = 0; m_full = 1; end
      end
    end else if (fs) begin
      m_filling = 1; m_count = 0;
    end
    if (fs) begin
      m_miss = 0; m_blank = 0;
    end else if (vfe) begin
      m_miss = (m_miss < 255) ? m_miss + 1 : 255;
      if (m_miss >= BLANK_FRAMES) m_blank = 1;
    end
  endtask

  task automatic step(input bit r, fs, wr, input logic [14:0] a, input logic [1:0] d, input bit vfe);
    @(negedge clk);
    chk("wren", fb_wren, e_wren);
    chk("wraddr", fb_wraddr, e_wraddr);
    chk("data", fb_data, e_data);
    chk("blank", blank, m_blank);
    chk("drops", drop_count, m_drops);
    if (fb_wren) nwr++;
    rst = r; in_frame_start = fs; in_wr = wr; in_addr = a; in_data = d;
    vga_frame_end = vfe; vga_rdaddr = 15'($urandom);
    #1 chk("rdaddr", fb_rdaddr, {m_front, vga_rdaddr});
    model(r, fs, wr, a, d, vfe);
  endtask

  task automatic idle();      step(0, 0, 0, '0, '0, 0); endtask
  task automatic fs_pulse();  step(0, 1, 0, '0, '0, 0); endtask
  task automatic vfe_pulse(); step(0, 0, 0, '0, '0, 1); endtask
  task automatic wr(input int a); step(0, 0, 1, 15'(a), 2'(a), 0); endtask
  // Observe the result of the last step's clock edge without skipping a cycle.
  task automatic settle(); @(posedge clk); #1; endtask

  initial begin
    // Reset state
    step(1, 0, 0, '0, '0, 0);
    settle();
    chk("rst_wren", fb_wren, 0);
    chk("rst_wraddr", fb_wraddr, 0);
    chk("rst_drops", drop_count, 0);
    chk("rst_blank", blank, 1);

    // Full frame then swap
    fs_pulse();
    settle();
    chk("blank_after_start", blank, 0);
    nwr = 0;
    for (int i = 0; i < PIXELS; i++) wr(i);
    idle(); idle();
    chk("frame_writes", nwr, 23040);
    vfe_pulse();
    settle();
    chk("front_after_swap", fb_rdaddr[15], 1);
    chk("blank_one_miss", blank, 0);
    vfe_pulse();
    settle();
    chk("blank_two_miss", blank, 1);

    // Partial frame dropped by a new start
    step(1, 0, 0, '0, '0, 0);
    fs_pulse();
    for (int i = 0; i < 100; i++) wr(i);
    fs_pulse();
    settle();
    chk("partial_drop", drop_count, 1);
    wr(5);
    settle();
    chk("restart_wren", fb_wren, 1);
    chk("restart_wraddr", fb_wraddr, 16'h8005);

    // Out-of-range pixel
    wr(PIXELS);
    settle();
    chk("oob_wren", fb_wren, 0);

    // Complete frame, then start before swap -> SKIP
    for (int i = 1; i < PIXELS; i++) wr(i);
    idle();
    fs_pulse();
    settle();
    chk("skip_drop", drop_count, 2);
    nwr = 0;
    for (int i = 0; i < 10; i++) wr(i);
    vfe_pulse();
    for (int i = 0; i < 10; i++) wr(i);
    idle();
    chk("skip_no_writes", nwr, 0);
    chk("skip_swapped", fb_rdaddr[15], 1);
    fs_pulse();
    wr(7);
    settle();
    chk("post_skip_wraddr", fb_wraddr, 16'h0007);

    // Same-cycle start and frame end in READY
    for (int i = 1; i < PIXELS; i++) wr(i);
    idle();
    step(0, 1, 0, '0, '0, 1);
    settle();
    chk("same_cycle_front", fb_rdaddr[15], 0);
    chk("same_cycle_drops", drop_count, 2);
    wr(9);
    settle();
    chk("same_cycle_wraddr", fb_wraddr, 16'h8009);

    // Random traffic
    for (int n = 0; n < 5000; n++) begin
      bit r, fs, w, v;
      int a;
      r  = ($urandom_range(0, 699) == 0);
      fs = ($urandom_range(0, 199) == 0);
      v  = ($urandom_range(0, 149) == 0);
      w  = $urandom_range(0, 1) == 1;
      a  = ($urandom_range(0, 3) == 0) ? $urandom_range(PIXELS - 4, PIXELS + 4)
                                         : $urandom_range(0, PIXELS - 1);
      step(r, fs, w, 15'(a), 2'($urandom), v);
    end
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fb_page_ctrl.md
FB_PAGE_CTRL -- requirements
Module: fb_page_ctrl

Interface
REQ-001 SHALL have parameter PIXELS, default 23040, meaning pixels per complete GB frame (160x144).
REQ-002 SHALL have parameter BLANK_FRAMES, default 2, meaning VGA frames without GB frame start before blanking.
REQ-003 SHALL have port clk, input, 1, single clock (40 MHz PLL domain); all logic on rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port in_frame_start, input, 1, one-cycle pulse on filtered GB vsync rising edge.
REQ-006 SHALL have port in_wr, input, 1, one-cycle pulse: decoded GB pixel valid.
REQ-007 SHALL have port in_addr, input, 15, GB pixel index, 0..PIXELS-1.
REQ-008 SHALL have port in_data, input, 2, GB pixel value.
REQ-009 SHALL have port vga_frame_end, input, 1, one-cycle pulse when VGA counters wrap to frame start (in vertical blanking).
REQ-010 SHALL have port vga_rdaddr, input, 15, VGA read pixel index.
REQ-011 SHALL have port fb_wren, output, 1, framebuffer write enable.
REQ-012 SHALL have port fb_wraddr, output, 16, {back_page, address}.
REQ-013 SHALL have port fb_data, output, 2, write data.
REQ-014 SHALL have port fb_rdaddr, output, 16, {front_page, vga_rdaddr}, combinational.
REQ-015 SHALL have port blank, output, 1, display-white request to VGA output stage.
REQ-016 SHALL have port drop_count, output, 8, saturating count of discarded GB frames.

Function
REQ-017 SHALL hold front_page (read) and back_page = ~front_page (write); two pages only.
REQ-018 SHALL implement states IDLE, FILL, READY, SKIP.
REQ-019 IDLE: in_wr ignored; in_frame_start -> FILL, pixel count cleared to 0.
REQ-020 FILL: each in_wr issues a write to back_page and increments pixel count; when count reaches PIXELS -> READY on the cycle after the last write.
REQ-021 Write path SHALL be registered: fb_wren/fb_wraddr/fb_data valid exactly 1 cycle after in_wr; fb_wren high for one cycle per accepted write.
REQ-022 in_wr with in_addr >= PIXELS SHALL be discarded and not counted.
REQ-023 FILL + in_frame_start before count reaches PIXELS: partial frame dropped, drop_count++, count cleared, stay FILL.
REQ-024 READY: in_wr ignored; on vga_frame_end front_page toggles (swap) and state -> IDLE.
REQ-025 READY + in_frame_start (no vga_frame_end same cycle): new frame cannot be stored, drop_count++, state -> SKIP (swap still pending).
REQ-026 SKIP: in_wr ignored; vga_frame_end swaps -> IDLE; a further in_frame_start drops again (drop_count++), stay SKIP.
REQ-027 Same-cycle vga_frame_end and in_frame_start in READY or SKIP: swap first, then enter FILL with count 0 on new back_page; no drop.
REQ-028 Same-cycle in_frame_start and in_wr: frame start wins; that pixel SHALL NOT be written or counted.
REQ-029 front_page SHALL change only on vga_frame_end; fb_rdaddr SHALL never mix pages within a VGA frame.
REQ-030 drop_count SHALL saturate at 255.
REQ-031 Blank timer: in_frame_start clears miss counter and blank; each vga_frame_end without in_frame_start increments miss counter (saturating); blank = 1 once miss counter >= BLANK_FRAMES.
REQ-032 In_frame_start and vga_frame_end same cycle: miss counter cleared (start wins).
REQ-033 Blank assertion SHALL NOT alter state machine or page selection.

Reset
REQ-034 rst SHALL set state IDLE, front_page 0, count 0, fb_wren 0, fb_wraddr 0, fb_data 0, drop_count 0, miss counter 0, blank 1.
REQ-035 rst mid-FILL or mid-READY SHALL abandon frame without swap; no write issued on cycle following rst.

Verification
REQ-036 Reset, one frame_start, PIXELS writes with in_data=addr[1:0], then vga_frame_end -> 23040 writes at page 1, front_page 0->1, fb_rdaddr[15]=1.
REQ-037 frame_start, 100 writes, frame_start -> drop_count=1, state FILL, next write goes to {1,addr} with count restarting at 0.
REQ-038 Full frame then second frame_start before vga_frame_end -> drop_count=1, state SKIP, no fb_wren until vga_frame_end swaps and a new frame_start arrives.
REQ-039 READY with frame_start and vga_frame_end same cycle -> front_page toggles, state FILL, drop_count unchanged, next writes to new back_page.
REQ-040 After reset, blank=1; frame_start -> blank=0; two vga_frame_end with no frame_start -> blank=1 after second pulse.
REQ-041 in_wr with in_addr=23040 in FILL -> no fb_wren, count unchanged.
